// File: rtl/operand_sel_pipe.sv
// N-way operand selector feeding a two-entry (main + skid) registered output stage
// with valid/ready handshake, flush, and a sticky out-of-range select flag.
module operand_sel_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam int NUM_PAD = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_src [NUM_PAD];
  logic [WIDTH-1:0] w_word;
  logic             w_sel_ok;
  logic             w_accept;
  logic             w_pop;
  logic             w_main_we;
  logic             w_main_from_skid;
  logic             w_skid_we;

  // Select slots beyond NUM_IN alias source 0, so an out-of-range sel needs no extra mux.
  generate
    for (genvar gi = 0; gi < NUM_PAD; gi++) begin : g_src
      if (gi < NUM_IN) begin : g_real
        assign w_src[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_src[gi] = in_data[WIDTH-1:0];
      end
    end
  endgenerate

  assign w_word   = w_src[sel];
  assign w_sel_ok = ({1'b0, sel} < NUM_IN_W);

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_we        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_we        = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next = S_ONE;
          w_main_we    = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_main_we = 1'b1;
        end else if (w_accept) begin
          w_state_next = S_FULL;
          w_skid_we    = 1'b1;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_next     = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
    // Flush wins over everything except reset; buffered data is simply abandoned.
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_main_we        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_we        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_main_we) begin
        r_main <= w_word;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_we) begin
        r_skid <= w_word;
      end
      // An accept dropped by flush still reports its bad select.
      if (w_accept && !w_sel_ok) begin
        r_sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench: two instances (NUM_IN=4 and NUM_IN=3) share stimulus; a queue model
// predicts occupancy, words and sel_err, and a negedge monitor compares.
module tb_operand_sel_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [1:0]  sel;
  logic [31:0] src [4];

  logic [127:0] in_data4;
  logic [95:0]  in_data3;
  assign in_data4 = {src[3], src[2], src[1], src[0]};
  assign in_data3 = {src[2], src[1], src[0]};

  logic        in_ready4, out_valid4, sel_err4;
  logic [31:0] out_data4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [31:0] out_data3;

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready4), .flush(flush),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .sel_err(sel_err4)
  );

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready3), .flush(flush),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .sel_err(sel_err3)
  );

  int          checks = 0;
  int          errors = 0;
  int          cnt = 0;
  bit          err3_m = 1'b0;
  bit          zero_data = 1'b1;
  logic [31:0] q4 [$];
  logic [31:0] q3 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of capacity two, updated at each active edge.
  initial begin
    bit acc;
    bit pop;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cnt = 0;
        err3_m = 1'b0;
        zero_data = 1'b1;
        q4.delete();
        q3.delete();
      end else begin
        acc = in_valid && (cnt < 2);
        pop = (cnt > 0) && out_ready;
        if (acc && sel == 2'd3) err3_m = 1'b1;
        if (flush) begin
          cnt = 0;
          q4.delete();
          q3.delete();
        end else begin
          cnt = cnt - int'(pop) + int'(acc);
          if (acc) begin
            q4.push_back(src[sel]);
            q3.push_back((sel == 2'd3) ? src[0] : src[sel]);
            zero_data = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares state-derived outputs every cycle, pops the scoreboard on each transfer.
  initial begin
    logic [31:0] w4;
    logic [31:0] w3;
    forever begin
      @(negedge clk);
      chk("in_ready4", 32'(in_ready4), 32'(cnt < 2));
      chk("in_ready3", 32'(in_ready3), 32'(cnt < 2));
      chk("out_valid4", 32'(out_valid4), 32'(cnt > 0));
      chk("out_valid3", 32'(out_valid3), 32'(cnt > 0));
      chk("sel_err4", 32'(sel_err4), 32'd0);
      chk("sel_err3", 32'(sel_err3), 32'(err3_m));
      if (cnt > 0) begin
        if (q4.size() == 0 || q3.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty actual=%0d required=%0d", q4.size(), cnt);
        end else begin
          w4 = q4[0];
          w3 = q3[0];
          chk("out_data4", out_data4, w4);
          chk("out_data3", out_data3, w3);
          if (rst_n && out_ready) begin
            void'(q4.pop_front());
            void'(q3.pop_front());
            $display("POP t=%0t dut4=%h dut3=%h", $time, out_data4, out_data3);
          end
        end
      end else if (zero_data) begin
        chk("reset_data4", out_data4, 32'd0);
        chk("reset_data3", out_data3, 32'd0);
      end
    end
  end

  task automatic drive(input bit rn, input bit v, input logic [1:0] s, input bit f, input bit ordy);
    @(posedge clk);
    #1;
    rst_n = rn;
    in_valid = v;
    sel = s;
    flush = f;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    flush = 1'b0;
    out_ready = 1'b1;
    src[0] = 32'hA0; src[1] = 32'hB1; src[2] = 32'hC2; src[3] = 32'hD3;

    // Reset with in_valid high: must be ignored.
    drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Streaming, out_ready held high; sel=3 is out of range for the 3-input instance.
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Backpressure: two words absorbed, a third offered while full, then drain.
    drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Flush while full, with a word offered in the same cycle.
    drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Reset while full, in_valid asserted during the reset cycle.
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    if (q4.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q4.size() + q3.size());
    end
    checks++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised N-way operand selector with a registered, back-pressurable output stage for the pipelined RISC-V core. It replaces the fixed 3-input combinational forwarding mux wherever the selected operand must cross a stage boundary: it picks one of NUM_IN source words, captures it with a valid/ready handshake, and absorbs one cycle of downstream stall in an internal skid register. It also supports a pipeline flush and flags sticky out-of-range selects.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- NUM_IN, 4, number of source inputs (≥2); SEL_W = $clog2(NUM_IN) is a derived localparam

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge
- in_data  input  NUM_IN*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  source index; only meaningful with in_valid
- in_valid  input  1  upstream offers {in_data[sel]}
- in_ready  output  1  block can accept this cycle
- flush  input  1  discard all buffered and incoming words
- out_data  output  WIDTH  buffered head word
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream consumes when out_valid is high
- sel_err  output  1  sticky flag: an accepted word used an out-of-range sel

## Operation
- Selection: word = in_data[sel*WIDTH +: WIDTH] when sel < NUM_IN. Otherwise word = source 0, matching the existing mux default.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives out_data) plus one skid register. Three states:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- in_ready = (state != FULL). It is a pure function of registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY); out_data = main register.
- Transitions (non-flush cycles):
  - EMPTY: accept → ONE, main ← word. No accept → EMPTY.
  - ONE:
    - accept & pop → ONE, main ← word.
    - accept & !pop → FULL, skid ← word.
    - !accept & pop → EMPTY.
    - Otherwise hold.
  - FULL: pop → ONE, main ← skid. No pop → hold. No accept is possible in FULL.
- Flush: state → EMPTY on the next edge, from any state.
  - A simultaneous accept is dropped.
  - A simultaneous pop still counts as a downstream transfer, which is the downstream's concern.
  - Data registers need not be cleared.
  - sel_err is unaffected.
- sel_err: set on any accept with sel ≥ NUM_IN, including an accept dropped by flush. Cleared only by reset.
- When NUM_IN is a power of two, sel can never be out of range and sel_err stays 0.
- Priority per edge: reset > flush > normal transitions.

## Timing
- Reset (rst_n low at an edge): state EMPTY, main and skid data ← 0, sel_err ← 0.
  - After that edge: out_valid=0, out_data=0, in_ready=1, sel_err=0.
  - in_valid is ignored in any cycle where rst_n is low.
  - Reset mid-transfer drops all buffered words with no partial output.
- Latency: a word accepted at edge t is on out_data with out_valid=1 after edge t. This holds when the buffer was EMPTY, or was ONE with pop at t.
- Throughput: 1 word/cycle while out_ready stays high.
- Stall absorption: one extra word is accepted after out_ready drops. in_ready falls on the edge that fills the skid register and rises on the edge after the first pop.
- Ordering: strictly FIFO. No word is duplicated or lost except by flush or reset.
- out_data is stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then stream, WIDTH=32, NUM_IN=4, sources {0xA0,0xB1,0xC2,0xD3}, out_ready=1. Apply sel=2,0,3,1 on consecutive cycles. Required: out_data 0xC2,0xA0,0xD3,0xB1, each one cycle after accept, in_ready constantly 1.
- Backpressure: out_ready=0 while in_valid=1 with sel=1 then sel=2. Required: both words accepted, in_ready=0 after the second edge, out_data held at 0xB1. When out_ready=1: pops 0xB1 then 0xC2, and in_ready returns to 1 after the first pop.
- Out-of-range, NUM_IN=3: accept with sel=3. Required: out_data = source 0 and sel_err=1 after that edge; sel_err stays 1 through a later flush and clears only on reset.
- Flush in FULL: fill both registers, then assert flush together with in_valid. Required: out_valid=0 and in_ready=1 after the edge; the flush-cycle word is never emitted.
- Reset mid-operation: rst_n low for one cycle while in FULL state. Required: after the edge out_valid=0, out_data=0, in_ready=1, sel_err=0; in_valid asserted during that reset cycle produces no output.
